instruction_fetch_buffer: RTL and testbench
===========================================

INSTRUCTION_FETCH_BUFFER -- requirements
Module: instruction_fetch_buffer

Interface
REQ-001 The block SHALL have the following parameters:
- BUFFER_DEPTH, 4, FIFO entries, power of two, at least 2.
- BOOT_ADDRESS, 32'h0000_0000, PC after reset.

REQ-002 The block SHALL have the following ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- imem_req_o  out  1  fetch request valid.
- imem_addr_o  out  32  fetch address, word aligned.
- imem_gnt_i  in  1  memory accepts request this cycle.
- imem_valid_i  in  1  response data valid.
- imem_rdata_i  in  32  fetched word, instruction_t.
- flush_i  in  1  redirect (branch/jump/trap).
- flush_addr_i  in  32  redirect target.
- instr_o  out  32  head instruction, instruction_t.
- instr_pc_o  out  32  PC of instr_o.
- instr_valid_o  out  1  head valid.
- instr_ready_i  in  1  decode accepts head.

Function
REQ-003 The block SHALL keep fetch PC register fpc; imem_addr_o = fpc.
REQ-004 The block SHALL advance fpc by 4 on imem_req_o & imem_gnt_i, modulo 2^32 (0xFFFF_FFFC wraps to 0).
REQ-005 The block SHALL have exactly one outstanding request, using an FSM with the following states:
- IDLE: no request outstanding.
- WAIT: response pending, data kept.
- DISCARD: response pending, data dropped.
REQ-006 The block SHALL drive imem_req_o = (state==IDLE) & (count<BUFFER_DEPTH) & ~flush_i, with imem_req_o held stable with constant imem_addr_o until granted.
REQ-007 The FSM SHALL make the following transitions:
- IDLE->WAIT on grant.
- WAIT->IDLE on imem_valid_i, pushing {imem_rdata_i, request PC}.
- WAIT->DISCARD on flush_i without imem_valid_i.
- WAIT->IDLE on flush_i with imem_valid_i, response dropped.
- DISCARD->IDLE on imem_valid_i, response dropped.
REQ-008 The block SHALL latch the request PC on grant; the pushed entry carries that PC, not fpc.
REQ-009 The FIFO SHALL be circular with wrapping read/write pointers and count 0..BUFFER_DEPTH; REQ-006 guarantees no push when full.
REQ-010 The block SHALL drive instr_valid_o = (count!=0); instr_o/instr_pc_o = head entry; pop on instr_valid_o & instr_ready_i.
REQ-011 On simultaneous push and pop, count SHALL remain unchanged and both pointers SHALL advance.
REQ-012 flush_i SHALL have priority over push, pop and grant and act as follows:
- Next cycle: count=0, pointers=0, fpc = {flush_addr_i[31:2],2'b00}.
- instr_valid_o low the cycle after flush.
REQ-013 instr_o/instr_pc_o SHALL be don't-care while instr_valid_o is low.
REQ-014 Instruction bits SHALL pass unmodified; no decoding.

Reset
REQ-015 When rst_n_i is low, regardless of clock, the block SHALL set:
- state=IDLE, fpc=BOOT_ADDRESS, count=0, pointers=0.
- imem_req_o=0, instr_valid_o=0.
REQ-016 Reset mid-request SHALL abandon the outstanding request; memory SHALL not deliver stale responses after reset.
REQ-017 The first request SHALL be issued the first cycle after rst_n_i deasserts.

Configuration
REQ-018 With IBUF_BYPASS_EN defined, bypass SHALL be active when count==0, state==WAIT, imem_valid_i=1 and flush_i=0:
- instr_valid_o=1 combinationally, with instr_o=imem_rdata_i and instr_pc_o=request PC.
- If instr_ready_i=1, the word is consumed without entering the FIFO; otherwise it is pushed.
REQ-019 Without IBUF_BYPASS_EN, all responses SHALL be pushed; minimum latency from imem_valid_i to instr_valid_o is 1 cycle.

Verification
REQ-020 Reset release, gnt=1, valid one cycle after each grant, ready=1 -> addresses 0x0,0x4,0x8 issued; instr_pc_o sequence 0x0,0x4,0x8 in order.
REQ-021 ready=0 for 10 cycles -> four entries buffered, imem_req_o low at count=4; ready=1 -> four pops, then requests resume at 0x10.
REQ-022 flush_i with flush_addr_i=0x0000_0103 while WAIT, response next cycle -> response dropped, next request 0x100, instr_valid_o low until 0x100 data returns.
REQ-023 flush_i in same cycle as imem_valid_i and a pop -> FIFO empty, no push, next request at target.
REQ-024 With IBUF_BYPASS_EN, empty FIFO, ready=1, response 0x00A00093 -> instr_o=0x00A00093 and instr_valid_o=1 same cycle; count stays 0; without the macro instr_valid_o rises one cycle later.
REQ-025 rst_n_i asserted asynchronously mid-WAIT with 3 entries -> outputs zero immediately; fpc=BOOT_ADDRESS after release.

Source files
------------

// File: rtl/instruction_fetch_buffer.sv
// Instruction fetch unit: one-outstanding-request memory front end feeding a circular FIFO.
// Optional same-cycle response bypass to decode when IBUF_BYPASS_EN is defined.
module instruction_fetch_buffer #(
   parameter int unsigned BUFFER_DEPTH = 4,
   parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_valid_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        flush_i,
   input  logic [31:0] flush_addr_i,
   output logic [31:0] instr_o,
   output logic [31:0] instr_pc_o,
   output logic        instr_valid_o,
   input  logic        instr_ready_i
);

   localparam int unsigned PtrW = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
   localparam int unsigned CntW = $clog2(BUFFER_DEPTH + 1);
   localparam logic [CntW-1:0] Depth = CntW'(BUFFER_DEPTH);

   typedef enum logic [1:0] {StIdle, StWait, StDiscard} state_e;

   state_e            state_q, state_d;
   logic [31:0]       fpc_q, fpc_d;
   logic [31:0]       req_pc_q, req_pc_d;
   logic [CntW-1:0]   count_q, count_d;
   logic [PtrW-1:0]   wptr_q, wptr_d;
   logic [PtrW-1:0]   rptr_q, rptr_d;
   logic [31:0]       instr_mem [BUFFER_DEPTH];
   logic [31:0]       pc_mem [BUFFER_DEPTH];

   logic grant;
   logic push;
   logic pop;
   logic bypass;
   logic fifo_empty;

   assign fifo_empty = (count_q == '0);

`ifdef IBUF_BYPASS_EN
   assign bypass = fifo_empty & (state_q == StWait) & imem_valid_i & ~flush_i;
`else
   assign bypass = 1'b0;
`endif

   // Gating with rst_n_i keeps the request low while reset is held.
   assign imem_req_o  = rst_n_i & (state_q == StIdle) & (count_q < Depth) & ~flush_i;
   assign imem_addr_o = fpc_q;
   assign grant       = imem_req_o & imem_gnt_i;

   // A bypassed word that decode takes this cycle never enters the FIFO.
   assign push = (state_q == StWait) & imem_valid_i & ~flush_i & ~(bypass & instr_ready_i);
   assign pop  = ~fifo_empty & instr_ready_i & ~flush_i;

   assign instr_valid_o = ~fifo_empty | bypass;
   assign instr_o       = bypass ? imem_rdata_i : instr_mem[rptr_q];
   assign instr_pc_o    = bypass ? req_pc_q : pc_mem[rptr_q];

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (grant) state_d = StWait;
         end
         StWait: begin
            if (imem_valid_i) state_d = StIdle;
            else if (flush_i) state_d = StDiscard;
         end
         StDiscard: begin
            if (imem_valid_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      fpc_d    = fpc_q;
      req_pc_d = req_pc_q;
      count_d  = count_q;
      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      if (grant) req_pc_d = fpc_q;
      if (flush_i) begin
         fpc_d   = {flush_addr_i[31:2], 2'b00};
         count_d = '0;
         wptr_d  = '0;
         rptr_d  = '0;
      end else begin
         if (grant) fpc_d = fpc_q + 32'd4;
         if (push) wptr_d = wptr_q + 1'b1;
         if (pop) rptr_d = rptr_q + 1'b1;
         if (push && !pop) count_d = count_q + 1'b1;
         else if (pop && !push) count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= StIdle;
         fpc_q    <= BOOT_ADDRESS;
         req_pc_q <= BOOT_ADDRESS;
         count_q  <= '0;
         wptr_q   <= '0;
         rptr_q   <= '0;
      end else begin
         state_q  <= state_d;
         fpc_q    <= fpc_d;
         req_pc_q <= req_pc_d;
         count_q  <= count_d;
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
      end
   end

   // Storage needs no reset: entries are only read while count is non-zero.
   always_ff @(posedge clk_i) begin
      if (push) begin
         instr_mem[wptr_q] <= imem_rdata_i;
         pc_mem[wptr_q]    <= req_pc_q;
      end
   end

endmodule

// File: tb/tb_instruction_fetch_buffer.sv
// Self-checking bench for instruction_fetch_buffer: memory responder model plus
// scoreboard of expected {instr, pc} entries. Define IBUF_BYPASS_EN to match the RTL build.
module tb_instruction_fetch_buffer;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_valid_i;
   logic [31:0] imem_rdata_i;
   logic        flush_i;
   logic [31:0] flush_addr_i;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;
   logic        instr_valid_o;
   logic        instr_ready_i;

   always #5 clk_i = ~clk_i;

   instruction_fetch_buffer #(
      .BUFFER_DEPTH(4),
      .BOOT_ADDRESS(32'h0000_0000)
   ) dut (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .imem_req_o   (imem_req_o),
      .imem_addr_o  (imem_addr_o),
      .imem_gnt_i   (imem_gnt_i),
      .imem_valid_i (imem_valid_i),
      .imem_rdata_i (imem_rdata_i),
      .flush_i      (flush_i),
      .flush_addr_i (flush_addr_i),
      .instr_o      (instr_o),
      .instr_pc_o   (instr_pc_o),
      .instr_valid_o(instr_valid_o),
      .instr_ready_i(instr_ready_i)
   );

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } entry_t;

   int vectors = 0;
   int miscompares = 0;

   // Stimulus knobs
   bit          gnt_en, resp_en, ready, flush_req;
   logic [31:0] flush_target;

   // Reference model state
   bit          pending, drop;
   logic [31:0] pend_pc, exp_fpc;
   entry_t      sb[$];
   logic [31:0] popped_pc[$];

   // Last sampled DUT outputs
   logic        s_valid, s_req;
   logic [31:0] s_instr, s_addr;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return (a == 32'h40) ? 32'h00A0_0093 : (a ^ 32'h1357_9BDF);
   endfunction

   // One clock: drive, settle, check against the model, advance model, clock.
   task automatic cycle();
      bit     resp, byp, exp_req, exp_valid;
      int     cnt;
      entry_t e;
      resp          = pending && resp_en;
      imem_gnt_i    = gnt_en;
      imem_valid_i  = resp;
      imem_rdata_i  = resp ? mem_data(pend_pc) : 32'hDEAD_BEEF;
      instr_ready_i = ready;
      flush_i       = flush_req;
      flush_addr_i  = flush_target;
      #1;
      cnt     = sb.size();
      exp_req = !pending && (cnt < 4) && !flush_req;
`ifdef IBUF_BYPASS_EN
      byp = (cnt == 0) && pending && !drop && resp && !flush_req;
`else
      byp = 1'b0;
`endif
      exp_valid = (cnt != 0) || byp;
      s_valid = instr_valid_o;
      s_req   = imem_req_o;
      s_instr = instr_o;
      s_addr  = imem_addr_o;

      vectors++;
      if (imem_req_o !== exp_req) begin
         miscompares++;
         $display("FAIL req t=%0t got=%b exp=%b", $time, imem_req_o, exp_req);
      end
      if (exp_req) begin
         vectors++;
         if (imem_addr_o !== exp_fpc) begin
            miscompares++;
            $display("FAIL addr t=%0t got=%h exp=%h", $time, imem_addr_o, exp_fpc);
         end
      end
      vectors++;
      if (instr_valid_o !== exp_valid) begin
         miscompares++;
         $display("FAIL instr_valid t=%0t got=%b exp=%b", $time, instr_valid_o, exp_valid);
      end

      if (resp && !drop && !flush_req) sb.push_back('{mem_data(pend_pc), pend_pc});
      if (exp_valid && ready && sb.size() != 0) begin
         e = sb.pop_front();
         popped_pc.push_back(e.pc);
         vectors++;
         if (instr_o !== e.instr || instr_pc_o !== e.pc) begin
            miscompares++;
            $display("FAIL head t=%0t got=%h@%h exp=%h@%h", $time, instr_o, instr_pc_o,
                     e.instr, e.pc);
         end
      end

      if (resp) begin
         pending = 1'b0;
         drop    = 1'b0;
      end else if (flush_req && pending) begin
         drop = 1'b1;
      end
      if (flush_req) begin
         sb.delete();
         exp_fpc = {flush_target[31:2], 2'b00};
      end
      if (exp_req && gnt_en) begin
         pending = 1'b1;
         pend_pc = exp_fpc;
         exp_fpc = exp_fpc + 32'd4;
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic model_reset();
      pending = 1'b0;
      drop    = 1'b0;
      exp_fpc = 32'h0000_0000;
      sb.delete();
      popped_pc.delete();
   endtask

   task automatic apply_reset();
      rst_n_i       = 1'b0;
      imem_gnt_i    = 1'b0;
      imem_valid_i  = 1'b0;
      imem_rdata_i  = '0;
      flush_i       = 1'b0;
      flush_addr_i  = '0;
      instr_ready_i = 1'b0;
      flush_req     = 1'b0;
      model_reset();
      repeat (2) @(posedge clk_i);
      #1;
      rst_n_i = 1'b1;
   endtask

   task automatic test_reset();
      rst_n_i = 1'b0;
      #1;
      vectors++;
      if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_outputs got req=%b valid=%b exp 0/0", imem_req_o, instr_valid_o);
      end
      apply_reset();
      gnt_en  = 1'b1;
      resp_en = 1'b1;
      ready   = 1'b1;
      cycle();
      vectors++;
      if (s_req !== 1'b1 || s_addr !== 32'h0) begin
         miscompares++;
         $display("FAIL first_request got req=%b addr=%h exp 1/00000000", s_req, s_addr);
      end
   endtask

   task automatic test_basic();
      apply_reset();
      gnt_en  = 1'b1;
      resp_en = 1'b1;
      ready   = 1'b1;
      repeat (8) cycle();
      vectors++;
      if (popped_pc.size() < 3) begin
         miscompares++;
         $display("FAIL basic_count got=%0d exp>=3", popped_pc.size());
      end else if (popped_pc[0] !== 32'h0 || popped_pc[1] !== 32'h4 || popped_pc[2] !== 32'h8) begin
         miscompares++;
         $display("FAIL basic_order got=%h,%h,%h exp=0,4,8", popped_pc[0], popped_pc[1],
                  popped_pc[2]);
      end
   endtask

   task automatic test_backpressure();
      apply_reset();
      gnt_en  = 1'b1;
      resp_en = 1'b1;
      ready   = 1'b0;
      repeat (10) cycle();
      #1;
      vectors++;
      if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b1) begin
         miscompares++;
         $display("FAIL full_stall got req=%b valid=%b exp 0/1", imem_req_o, instr_valid_o);
      end
      ready = 1'b1;
      repeat (4) cycle();
      vectors++;
      if (popped_pc.size() != 4 || popped_pc[3] !== 32'hC) begin
         miscompares++;
         $display("FAIL drain got=%0d pops last=%h exp 4 pops last=0000000c", popped_pc.size(),
                  popped_pc.size() != 0 ? popped_pc[popped_pc.size()-1] : 32'h0);
      end
   endtask

   task automatic test_flush_wait();
      bit found = 1'b0;
      resp_en = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (pending) begin
            found = 1'b1;
            break;
         end
         cycle();
      end
      vectors++;
      if (!found) begin
         miscompares++;
         $display("FAIL flush_wait_setup got no pending request exp one");
      end
      flush_req    = 1'b1;
      flush_target = 32'h0000_0103;
      cycle();
      flush_req = 1'b0;
      resp_en   = 1'b1;
      popped_pc.delete();
      cycle();
      repeat (6) cycle();
      vectors++;
      if (popped_pc.size() == 0 || popped_pc[0] !== 32'h100) begin
         miscompares++;
         $display("FAIL flush_target got=%h exp=00000100",
                  popped_pc.size() != 0 ? popped_pc[0] : 32'hFFFF_FFFF);
      end
   endtask

   task automatic test_flush_resp_pop();
      bit found = 1'b0;
      ready   = 1'b0;
      resp_en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (sb.size() >= 2 && pending) begin
            found = 1'b1;
            break;
         end
         cycle();
      end
      vectors++;
      if (!found) begin
         miscompares++;
         $display("FAIL flush_pop_setup got no buffered+pending state exp one");
      end
      ready        = 1'b1;
      flush_req    = 1'b1;
      flush_target = 32'h0000_0200;
      cycle();
      flush_req = 1'b0;
      cycle();
      vectors++;
      if (s_valid !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'h200) begin
         miscompares++;
         $display("FAIL flush_pop got valid=%b req=%b addr=%h exp 0/1/00000200", s_valid, s_req,
                  s_addr);
      end
      repeat (4) cycle();
   endtask

   task automatic test_wrap();
      ready        = 1'b1;
      flush_req    = 1'b1;
      flush_target = 32'hFFFF_FFF8;
      cycle();
      flush_req = 1'b0;
      popped_pc.delete();
      repeat (12) cycle();
      vectors++;
      if (popped_pc.size() < 3 || popped_pc[0] !== 32'hFFFF_FFF8 ||
          popped_pc[1] !== 32'hFFFF_FFFC || popped_pc[2] !== 32'h0) begin
         miscompares++;
         $display("FAIL wrap got %0d pops exp fffffff8,fffffffc,00000000", popped_pc.size());
      end
   endtask

   task automatic test_bypass_latency();
      bit found = 1'b0;
      bit exp_now;
      ready        = 1'b1;
      resp_en      = 1'b1;
      flush_req    = 1'b1;
      flush_target = 32'h0000_0040;
      cycle();
      flush_req = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (pending && !drop && pend_pc == 32'h40) begin
            found = 1'b1;
            break;
         end
         cycle();
      end
      vectors++;
      if (!found) begin
         miscompares++;
         $display("FAIL bypass_setup got no request for 00000040 exp one");
      end
`ifdef IBUF_BYPASS_EN
      exp_now = 1'b1;
`else
      exp_now = 1'b0;
`endif
      cycle();
      vectors++;
      if (s_valid !== exp_now || (exp_now && s_instr !== 32'h00A0_0093)) begin
         miscompares++;
         $display("FAIL resp_cycle got valid=%b instr=%h exp valid=%b", s_valid, s_instr,
                  exp_now);
      end
      cycle();
      vectors++;
      if (s_valid !== !exp_now || (!exp_now && s_instr !== 32'h00A0_0093)) begin
         miscompares++;
         $display("FAIL next_cycle got valid=%b instr=%h exp valid=%b", s_valid, s_instr,
                  !exp_now);
      end
      repeat (2) cycle();
   endtask

   task automatic test_reset_mid();
      bit found = 1'b0;
      ready   = 1'b0;
      gnt_en  = 1'b1;
      resp_en = 1'b1;
      for (int i = 0; i < 30; i++) begin
         if (sb.size() == 3 && pending) begin
            found = 1'b1;
            break;
         end
         cycle();
      end
      vectors++;
      if (!found) begin
         miscompares++;
         $display("FAIL reset_mid_setup got no 3-entry WAIT state exp one");
      end
      #2;
      rst_n_i = 1'b0;
      #1;
      vectors++;
      if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset got req=%b valid=%b exp 0/0", imem_req_o, instr_valid_o);
      end
      apply_reset();
      ready = 1'b1;
      cycle();
      vectors++;
      if (s_req !== 1'b1 || s_addr !== 32'h0) begin
         miscompares++;
         $display("FAIL boot_after_reset got req=%b addr=%h exp 1/00000000", s_req, s_addr);
      end
      repeat (6) cycle();
   endtask

   initial begin
      gnt_en       = 1'b0;
      resp_en      = 1'b0;
      ready        = 1'b0;
      flush_req    = 1'b0;
      flush_target = '0;
      model_reset();
      test_reset();
      test_basic();
      test_backpressure();
      test_flush_wait();
      test_flush_resp_pop();
      test_wrap();
      test_bypass_latency();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
